approx_err_accum: RTL and testbench

- Sequential error-metric stage directly downstream of the 16-bit approximate ripple-carry adders in the area-mse flow.
- Consumes operand pairs and the approximate adder's 17-bit sum, and computes the exact sum internally.
- Over a window of 2^LOG2_WINDOW samples it accumulates squared error distance (SSE, i.e. MSE × window), maximum error distance, worst-case operands and erroneous-sample count.
- Results feed simulation-based cross-checks of the formally derived MSE bounds.

---
 rtl/approx_err_accum.sv | 176 +++++++++++++++++
 tb/tb_approx_err_accum.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/approx_err_accum.sv
// rtl/approx_err_accum.sv - windowed squared/max error accumulator for approximate adders
// Two-stage pipeline (error distance, then accumulate) behind an IDLE/RUN/DRAIN/DONE controller.
module approx_err_accum #(
    parameter int WIDTH       = 16,
    parameter int LOG2_WINDOW = 8,
    localparam int ACC_W      = 2*(WIDTH+1)+LOG2_WINDOW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       IN1,
    input  logic [WIDTH-1:0]       IN2,
    input  logic [WIDTH:0]         APPROX,
    output logic                   busy,
    output logic                   done,
    output logic [ACC_W-1:0]       sse,
    output logic [WIDTH:0]         max_ed,
    output logic [WIDTH-1:0]       wce_in1,
    output logic [WIDTH-1:0]       wce_in2,
    output logic [LOG2_WINDOW:0]   err_cnt
);

    localparam int CNT_W = LOG2_WINDOW + 1;
    localparam int SQ_W  = 2*(WIDTH+1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << LOG2_WINDOW) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drain_q, drain_d;

    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH:0]     s1_ed_q, s1_ed_d;
    logic [WIDTH-1:0]   s1_in1_q, s1_in1_d;
    logic [WIDTH-1:0]   s1_in2_q, s1_in2_d;

    logic [ACC_W-1:0]   sse_q, sse_d;
    logic [WIDTH:0]     max_ed_q, max_ed_d;
    logic [WIDTH-1:0]   wce_in1_q, wce_in1_d;
    logic [WIDTH-1:0]   wce_in2_q, wce_in2_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic               accept;
    logic               last_accept;
    logic               window_start;
    logic [WIDTH:0]     exact;
    logic [SQ_W-1:0]    ed_sq;

    assign in_ready     = (state_q == S_RUN);
    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign accept       = in_valid && in_ready;
    assign last_accept  = accept && (cnt_q == LAST_IDX);
    assign window_start = (state_q == S_IDLE) && start;

    // Exact sum carries into bit WIDTH, so it never overflows.
    assign exact = {1'b0, IN1} + {1'b0, IN2};
    assign ed_sq = {{(WIDTH+1){1'b0}}, s1_ed_q} * {{(WIDTH+1){1'b0}}, s1_ed_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (last_accept) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        s1_valid_d = accept;
        s1_ed_d    = s1_ed_q;
        s1_in1_d   = s1_in1_q;
        s1_in2_d   = s1_in2_q;
        if (accept) begin
            s1_ed_d  = (exact >= APPROX) ? (exact - APPROX) : (APPROX - exact);
            s1_in1_d = IN1;
            s1_in2_d = IN2;
        end
    end

    // Strict '>' keeps the earliest worst-case sample on ties.
    always_comb begin
        sse_d     = sse_q;
        max_ed_d  = max_ed_q;
        wce_in1_d = wce_in1_q;
        wce_in2_d = wce_in2_q;
        err_cnt_d = err_cnt_q;
        if (window_start) begin
            sse_d     = '0;
            max_ed_d  = '0;
            wce_in1_d = '0;
            wce_in2_d = '0;
            err_cnt_d = '0;
        end else if (s1_valid_q) begin
            sse_d = sse_q + {{LOG2_WINDOW{1'b0}}, ed_sq};
            if (s1_ed_q != '0) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (s1_ed_q > max_ed_q) begin
                max_ed_d  = s1_ed_q;
                wce_in1_d = s1_in1_q;
                wce_in2_d = s1_in2_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            drain_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_ed_q    <= '0;
            s1_in1_q   <= '0;
            s1_in2_q   <= '0;
            sse_q      <= '0;
            max_ed_q   <= '0;
            wce_in1_q  <= '0;
            wce_in2_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            s1_valid_q <= s1_valid_d;
            s1_ed_q    <= s1_ed_d;
            s1_in1_q   <= s1_in1_d;
            s1_in2_q   <= s1_in2_d;
            sse_q      <= sse_d;
            max_ed_q   <= max_ed_d;
            wce_in1_q  <= wce_in1_d;
            wce_in2_q  <= wce_in2_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign sse     = sse_q;
    assign max_ed  = max_ed_q;
    assign wce_in1 = wce_in1_q;
    assign wce_in2 = wce_in2_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_approx_err_accum.sv
// tb/tb_approx_err_accum.sv - self-checking bench for approx_err_accum
// Window vectors from a table; expected results queued at start and popped on done.
module tb_approx_err_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic [16:0] approx = '0;
    logic        busy;
    logic        done;
    logic [41:0] sse;
    logic [16:0] max_ed;
    logic [15:0] wce_in1;
    logic [15:0] wce_in2;
    logic [8:0]  err_cnt;

    approx_err_accum dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .IN1(in1), .IN2(in2), .APPROX(approx), .busy(busy), .done(done),
        .sse(sse), .max_ed(max_ed), .wce_in1(wce_in1), .wce_in2(wce_in2), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] sse;
        logic [16:0] max_ed;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [8:0]  err;
    } exp_t;

    typedef struct {
        logic [15:0] a0; logic [15:0] b0; logic [16:0] x0;
        logic [15:0] a;  logic [15:0] b;  logic [16:0] x;
        bit          gap;
        exp_t        e;
    } vec_t;

    vec_t  vecs[6];
    exp_t  sb[$];
    int    n_vec = 0;
    int    n_fail = 0;
    int    done_cnt = 0;
    int    cyc = 0;
    int    last_acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 required no pending window");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_latency", 64'(cyc - last_acc_cyc), 64'd3);
                chk("busy_at_done", {63'd0, busy}, 64'd0);
                chk("sse", {22'd0, sse}, e.sse);
                chk("max_ed", {47'd0, max_ed}, {47'd0, e.max_ed});
                chk("wce_in1", {48'd0, wce_in1}, {48'd0, e.w1});
                chk("wce_in2", {48'd0, wce_in2}, {48'd0, e.w2});
                chk("err_cnt", {55'd0, err_cnt}, {55'd0, e.err});
            end
            done_cnt++;
        end
    end

    // Sends n samples; sample 0 uses (a0,b0,x0). start is raised alongside sample start_at.
    task automatic send_samples(input int n, input vec_t v, input int start_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start    = (i == start_at);
            in_valid = 1'b1;
            in1      = (i == 0) ? v.a0 : v.a;
            in2      = (i == 0) ? v.b0 : v.b;
            approx   = (i == 0) ? v.x0 : v.x;
            if (!in_ready) begin
                chk("in_ready_run", {63'd0, in_ready}, 64'd1);
                return;
            end
            last_acc_cyc = cyc;
            if (v.gap) begin
                @(negedge clk);
                start    = 1'b0;
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit poke_start);
        bit got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                got = 1'b1;
                if (poke_start) start = 1'b1;
                break;
            end
            chk("in_ready_drain", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        chk("done_seen", {63'd0, got}, 64'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_window(input vec_t v, input int start_at, input bit poke_start);
        sb.push_back(v.e);
        @(negedge clk);
        start = 1'b1;
        send_samples(256, v, start_at);
        wait_done(poke_start);
    endtask

    initial begin
        vecs[0] = '{a0:16'd0, b0:16'd0, x0:17'd0, a:16'd0, b:16'd0, x:17'd0, gap:1'b0,
                    e:'{sse:64'd0, max_ed:17'd0, w1:16'd0, w2:16'd0, err:9'd0}};
        vecs[1] = '{a0:16'd3, b0:16'd5, x0:17'd6, a:16'd3, b:16'd5, x:17'd6, gap:1'b0,
                    e:'{sse:64'd1024, max_ed:17'd2, w1:16'd3, w2:16'd5, err:9'd256}};
        vecs[2] = '{a0:16'hFFFF, b0:16'hFFFF, x0:17'd0, a:16'd1, b:16'd2, x:17'd3, gap:1'b0,
                    e:'{sse:64'd17179344900, max_ed:17'h1FFFE, w1:16'hFFFF, w2:16'hFFFF, err:9'd1}};
        vecs[3] = '{a0:16'hFFFF, b0:16'hFFFF, x0:17'd0, a:16'hFFFF, b:16'hFFFF, x:17'd0, gap:1'b0,
                    e:'{sse:64'd4397912294400, max_ed:17'h1FFFE, w1:16'hFFFF, w2:16'hFFFF, err:9'd256}};
        vecs[4] = '{a0:16'd1, b0:16'd2, x0:17'd10, a:16'd9, b:16'd9, x:17'd11, gap:1'b1,
                    e:'{sse:64'd12544, max_ed:17'd7, w1:16'd1, w2:16'd2, err:9'd256}};
        vecs[5] = '{a0:16'd0, b0:16'd0, x0:17'h1FFFF, a:16'd0, b:16'd0, x:17'h1FFFF, gap:1'b0,
                    e:'{sse:64'd4397979402496, max_ed:17'h1FFFF, w1:16'd0, w2:16'd0, err:9'd256}};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_sse", {22'd0, sse}, 64'd0);
        chk("rst_err_cnt", {55'd0, err_cnt}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_window(vecs[i], -1, 1'b0);
        end

        // start mid-window and during DONE must not clear or restart anything
        run_window(vecs[1], 100, 1'b1);
        chk("held_busy", {63'd0, busy}, 64'd0);
        chk("held_in_ready", {63'd0, in_ready}, 64'd0);
        chk("held_sse", {22'd0, sse}, 64'd1024);
        chk("held_err_cnt", {55'd0, err_cnt}, 64'd256);

        // reset after 100 accepts abandons the window without done
        @(negedge clk);
        start = 1'b1;
        send_samples(100, vecs[4], -1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_sse", {22'd0, sse}, 64'd0);
        chk("mid_rst_max_ed", {47'd0, max_ed}, 64'd0);
        chk("mid_rst_wce_in1", {48'd0, wce_in1}, 64'd0);
        chk("mid_rst_wce_in2", {48'd0, wce_in2}, 64'd0);
        chk("mid_rst_err_cnt", {55'd0, err_cnt}, 64'd0);
        repeat (10) @(negedge clk);
        run_window(vecs[2], -1, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("done_count", 64'(done_cnt), 64'd8);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
